citron_uart: RTL and testbench

//  Parametrised UART peripheral on the Citron bus. Next generation of the fixed 8-deep SPART.

---
 rtl/citron_uart_pkg.sv | 44 ++++
 rtl/citron_uart_fifo.sv | 58 +++++
 rtl/citron_uart.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_citron_uart.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/citron_uart_pkg.sv
// citron_uart_pkg: shared definitions for the Citron bus UART.
//  - register indices (citron_addr[2:0])
//  - STAT / CTRL / FLAGS bit positions
//  - TX / RX state enums and the latched frame format struct
package citron_uart_pkg;

  localparam logic [2:0] REG_DATA  = 3'd0;
  localparam logic [2:0] REG_STAT  = 3'd1;
  localparam logic [2:0] REG_DIV   = 3'd2;
  localparam logic [2:0] REG_CTRL  = 3'd3;
  localparam logic [2:0] REG_FLAGS = 3'd4;

  localparam int unsigned STAT_TX_IDLE  = 18;
  localparam int unsigned STAT_RX_EMPTY = 17;
  localparam int unsigned STAT_TX_FULL  = 16;

  localparam int unsigned CTRL_PAR_EN  = 2;
  localparam int unsigned CTRL_PAR_ODD = 3;
  localparam int unsigned CTRL_STOP2   = 4;
  localparam int unsigned CTRL_IE_LSB  = 8;   // [8] rx_nonempty, [9] tx_empty, [10] err

  localparam int unsigned FLAG_RX_OVERRUN = 0;
  localparam int unsigned FLAG_PARITY     = 1;
  localparam int unsigned FLAG_FRAMING    = 2;
  localparam int unsigned FLAG_TX_OVF     = 3;

  localparam logic [15:0] DIV_MIN = 16'd16;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  typedef struct packed {
    logic [1:0] bits;     // data bits - 5
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } frame_cfg_t;

  // Mask of the valid data bits for a given bits field (3 -> 8'hFF, 0 -> 8'h1F).
  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    return 8'hFF >> (3'd3 - {1'b0, bits});
  endfunction

endpackage

// File: rtl/citron_uart_fifo.sv
// uart_fifo: synchronous FIFO used for the UART TX and RX paths.
//  clk, rst_n     clock, asynchronous active-low reset
//  push, din      write request and data
//  pop, dout      read request; dout shows the head entry (combinational)
//  full, empty    status
//  count          number of stored entries (0..DEPTH)
// Pointers carry an extra wrap bit; full is equal index with differing wrap bit.
// Push into a full FIFO succeeds only if a pop happens in the same cycle;
// a pop on an empty FIFO is ignored.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/citron_uart.sv
// citron_uart: Citron bus UART with TX/RX FIFOs, runtime divisor, configurable
// frame format, sticky error flags and a level interrupt.
//  clk, rst_n          clock, asynchronous active-low reset
//  citron_addr/rdy/wr/writedata   bus request (byte payloads in [31:24])
//  citron_readdata     registered read data, valid the cycle after the request
//  citron_stall        always 0
//  citron_match        combinational address match on citron_addr[7:3]
//  irq                 registered OR of enabled interrupt causes
//  all_done            TX FIFO empty and TX FSM idle
//  TX / RX             serial pins (TX idles high, RX asynchronous)
module citron_uart
  import citron_uart_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'h10,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter logic [15:0] DIV_RESET   = 16'd434,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  citron_addr,
  input  logic        citron_rdy,
  input  logic        citron_wr,
  input  logic [31:0] citron_writedata,
  output logic [31:0] citron_readdata,
  output logic        citron_stall,
  output logic        citron_match,
  output logic        irq,
  output logic        all_done,
  output logic        TX,
  input  logic        RX
);

  localparam int unsigned TCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RX_DEPTH) + 1;

  // ---------------- bus decode ----------------
  logic       rd_acc, wr_acc;
  logic [2:0] reg_idx;
  logic       wd_unused;

  assign citron_match = (citron_addr[7:3] == BASE_ADDR[7:3]);
  assign citron_stall = 1'b0;
  assign rd_acc       = citron_rdy & citron_match & ~citron_wr;
  assign wr_acc       = citron_rdy & citron_match &  citron_wr;
  assign reg_idx      = citron_addr[2:0];
  assign wd_unused    = ^citron_writedata[23:16];

  // ---------------- FIFOs ----------------
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]     tx_dout;
  logic [TCW-1:0] tx_count;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]     rx_dout, rx_din;
  logic [RCW-1:0] rx_count;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(citron_writedata[31:24]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_din),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // ---------------- registers ----------------
  logic [15:0] div_q, div_d;
  frame_cfg_t  cfg_q, cfg_d;
  logic [2:0]  ie_q, ie_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] readdata_q, readdata_d;
  logic        irq_q, irq_d;
  logic        tx_idle;
  logic        rx_par_err_set, rx_frm_err_set;

  assign citron_readdata = readdata_q;
  assign irq             = irq_q;
  assign all_done        = tx_empty & tx_idle;

  always_comb begin
    div_d      = div_q;
    cfg_d      = cfg_q;
    ie_d       = ie_q;
    flags_d    = flags_q;
    readdata_d = readdata_q;
    tx_push    = 1'b0;
    rx_pop     = 1'b0;

    if (wr_acc) begin
      case (reg_idx)
        REG_DATA:  tx_push = 1'b1;
        REG_DIV:   div_d = (citron_writedata[15:0] < DIV_MIN) ? DIV_MIN : citron_writedata[15:0];
        REG_CTRL: begin
          cfg_d.bits    = citron_writedata[1:0];
          cfg_d.par_en  = citron_writedata[CTRL_PAR_EN];
          cfg_d.par_odd = citron_writedata[CTRL_PAR_ODD];
          cfg_d.stop2   = citron_writedata[CTRL_STOP2];
          ie_d          = citron_writedata[CTRL_IE_LSB +: 3];
        end
        REG_FLAGS: flags_d = flags_q & ~citron_writedata[3:0];
        default: ;
      endcase
    end

    if (rd_acc) begin
      case (reg_idx)
        REG_DATA: begin
          if (rx_empty) readdata_d = 32'hFFFF_0000;
          else begin
            readdata_d = {rx_dout, 24'h0};
            rx_pop     = 1'b1;
          end
        end
        REG_STAT: begin
          readdata_d                = '0;
          readdata_d[STAT_TX_IDLE]  = tx_idle;
          readdata_d[STAT_RX_EMPTY] = rx_empty;
          readdata_d[STAT_TX_FULL]  = tx_full;
          readdata_d[15:8]          = 8'(TX_DEPTH) - 8'(tx_count);
          readdata_d[7:0]           = 8'(rx_count);
        end
        REG_DIV:   readdata_d = {16'h0, div_q};
        REG_CTRL:  readdata_d = {21'h0, ie_q, 3'b000, cfg_q.stop2, cfg_q.par_odd,
                                 cfg_q.par_en, cfg_q.bits};
        REG_FLAGS: readdata_d = {28'h0, flags_q};
        default:   readdata_d = '0;
      endcase
    end

    // New error events win over a same-cycle W1C.
    if (tx_push && tx_full && !tx_pop) flags_d[FLAG_TX_OVF]     = 1'b1;
    if (rx_push && rx_full && !rx_pop) flags_d[FLAG_RX_OVERRUN] = 1'b1;
    if (rx_par_err_set)                flags_d[FLAG_PARITY]     = 1'b1;
    if (rx_frm_err_set)                flags_d[FLAG_FRAMING]    = 1'b1;

    irq_d = (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty) | (ie_q[2] & |flags_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= DIV_RESET;
      cfg_q      <= '{bits: 2'd3, par_en: 1'b0, par_odd: 1'b0, stop2: 1'b0};
      ie_q       <= '0;
      flags_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      cfg_q      <= cfg_d;
      ie_q       <= ie_d;
      flags_q    <= flags_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  // ---------------- TX FSM ----------------
  // Format and divisor are latched at each start bit so register writes
  // only affect the following frame.
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_par_q, tx_par_d, tx_line_q, tx_line_d;
  frame_cfg_t  tx_cfg_q, tx_cfg_d;
  logic        tx_tick, tx_start_frame;

  assign tx_idle = (tx_state_q == TX_IDLE);
  assign TX      = tx_line_q;

  always_comb begin
    tx_state_d     = tx_state_q;
    tx_cnt_d       = tx_cnt_q;
    tx_div_d       = tx_div_q;
    tx_bit_d       = tx_bit_q;
    tx_sh_d        = tx_sh_q;
    tx_par_d       = tx_par_q;
    tx_cfg_d       = tx_cfg_q;
    tx_pop         = 1'b0;
    tx_start_frame = 1'b0;
    tx_tick        = (tx_cnt_q == tx_div_q - 16'd1);

    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 16'd1;

    case (tx_state_q)
      TX_IDLE:  tx_start_frame = ~tx_empty;
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit_q == 3'(tx_cfg_q.bits) + 3'd4) begin
          tx_state_d = tx_cfg_q.par_en ? TX_PARITY : TX_STOP;
          tx_bit_d   = '0;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = tx_sh_q >> 1;
        end
      end
      TX_PARITY: if (tx_tick) begin
        tx_state_d = TX_STOP;
        tx_bit_d   = '0;
      end
      TX_STOP: if (tx_tick) begin
        if (tx_cfg_q.stop2 && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
        else if (!tx_empty)                     tx_start_frame = 1'b1;
        else                                    tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (tx_start_frame) begin
      tx_pop     = 1'b1;
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_sh_d    = tx_dout;
      tx_cfg_d   = cfg_q;
      tx_div_d   = div_q;
      tx_par_d   = ^(tx_dout & data_mask(cfg_q.bits)) ^ cfg_q.par_odd;
    end

    case (tx_state_d)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_sh_d[0];
      TX_PARITY: tx_line_d = tx_par_d;
      default:   tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_RESET;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_cfg_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_cfg_q   <= tx_cfg_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // ---------------- RX FSM ----------------
  logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
  logic                   rx_s, rx_prev_q;
  rx_state_t              rx_state_q, rx_state_d;
  logic [15:0]            rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]             rx_bit_q, rx_bit_d;
  logic [7:0]             rx_sh_q, rx_sh_d;
  frame_cfg_t             rx_cfg_q, rx_cfg_d;
  logic                   rx_tick, rx_half;

  assign rx_s   = rx_sync_q[SYNC_STAGES-1];
  assign rx_din = rx_sh_q;

  always_comb begin
    rx_sync_d      = SYNC_STAGES'({rx_sync_q, RX});
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_div_d       = rx_div_q;
    rx_bit_d       = rx_bit_q;
    rx_sh_d        = rx_sh_q;
    rx_cfg_d       = rx_cfg_q;
    rx_push        = 1'b0;
    rx_par_err_set = 1'b0;
    rx_frm_err_set = 1'b0;
    rx_tick        = (rx_cnt_q == rx_div_q - 16'd1);
    rx_half        = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);

    if (rx_state_q != RX_IDLE) rx_cnt_d = rx_cnt_q + 16'd1;

    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
        rx_div_d   = div_q;
        rx_cfg_d   = cfg_q;
        rx_sh_d    = '0;
        rx_bit_d   = '0;
      end
      // From the half-bit point onward every sample lands mid-bit.
      RX_START: if (rx_half) begin
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        rx_cnt_d   = '0;
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_d          = '0;
        rx_sh_d[rx_bit_q] = rx_s;
        if (rx_bit_q == 3'(rx_cfg_q.bits) + 3'd4)
          rx_state_d = rx_cfg_q.par_en ? RX_PARITY : RX_STOP;
        else
          rx_bit_d = rx_bit_q + 3'd1;
      end
      RX_PARITY: if (rx_tick) begin
        rx_cnt_d       = '0;
        rx_par_err_set = (rx_s != (^rx_sh_q ^ rx_cfg_q.par_odd));
        rx_state_d     = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_frm_err_set = ~rx_s;
        rx_push        = 1'b1;
        rx_state_d     = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= '1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RESET;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_cfg_q   <= '0;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_cfg_q   <= rx_cfg_d;
    end
  end

endmodule

// File: tb/tb_citron_uart.sv
// tb_citron_uart: directed bench for citron_uart. Bus reads push their expected
// value onto a scoreboard queue popped by a read monitor; TX bytes push an
// expected {byte, divisor} popped by a serial-line monitor.
module tb_citron_uart;

  localparam logic [7:0] BASE = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  citron_addr;
  logic        citron_rdy, citron_wr;
  logic [31:0] citron_writedata, citron_readdata;
  logic        citron_stall, citron_match, irq, all_done, TX, RX;

  citron_uart #(
    .BASE_ADDR(8'h10), .TX_DEPTH(8), .RX_DEPTH(8), .DIV_RESET(16'd434), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .citron_addr(citron_addr), .citron_rdy(citron_rdy),
    .citron_wr(citron_wr), .citron_writedata(citron_writedata),
    .citron_readdata(citron_readdata), .citron_stall(citron_stall),
    .citron_match(citron_match), .irq(irq), .all_done(all_done), .TX(TX), .RX(RX)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // ---------------- read scoreboard ----------------
  logic [31:0] rd_exp_q[$];
  string       rd_nm_q[$];
  logic        rd_v;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_v <= 1'b0;
    else        rd_v <= citron_rdy && !citron_wr && (citron_addr[7:3] == BASE[7:3]);

  always @(negedge clk) begin
    if (rd_v) begin
      if (rd_exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got %h expected no read data", citron_readdata);
      end else begin
        chk(rd_nm_q.pop_front(), citron_readdata, rd_exp_q.pop_front());
      end
    end
  end

  // ---------------- TX line monitor (8N1) ----------------
  typedef struct {
    logic [7:0] b;
    int         div;
  } txe_t;
  txe_t tx_exp_q[$];

  initial begin : tx_mon
    txe_t       e;
    logic [7:0] got;
    forever begin
      @(negedge TX);
      if (rst_n && tx_exp_q.size() != 0) begin
        e = tx_exp_q.pop_front();
        repeat (e.div / 2) @(negedge clk);
        chk("tx_start_bit", {31'h0, TX}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (e.div) @(negedge clk);
          got[i] = TX;
        end
        repeat (e.div) @(negedge clk);
        chk("tx_byte", {24'h0, got}, {24'h0, e.b});
        chk("tx_stop_bit", {31'h0, TX}, 32'h1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_wr(input logic [2:0] idx, input logic [31:0] d);
    @(negedge clk);
    citron_addr = BASE + {5'h0, idx}; citron_wr = 1'b1; citron_writedata = d; citron_rdy = 1'b1;
    @(posedge clk);
    #1 citron_rdy = 1'b0; citron_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] idx, input logic [31:0] exp, input string nm);
    @(negedge clk);
    citron_addr = BASE + {5'h0, idx}; citron_wr = 1'b0; citron_rdy = 1'b1;
    rd_exp_q.push_back(exp);
    rd_nm_q.push_back(nm);
    @(posedge clk);
    #1 citron_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int limit, input string nm);
    int k = 0;
    while (!all_done && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'h0, all_done}, 32'h1);
  endtask

  task automatic send_rx(input logic [7:0] data, input int nbits, input bit par_en,
                         input bit par_bit, input bit stop_bit, input int div);
    @(negedge clk);
    RX = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      RX = data[i];
      repeat (div) @(negedge clk);
    end
    if (par_en) begin
      RX = par_bit;
      repeat (div) @(negedge clk);
    end
    RX = stop_bit;
    repeat (div) @(negedge clk);
    RX = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int k, n;
    txe_t e;
    rst_n = 1'b0; citron_rdy = 1'b0; citron_wr = 1'b0; citron_addr = '0;
    citron_writedata = '0; RX = 1'b1;
    idle(3);
    chk("rst_tx", {31'h0, TX}, 32'h1);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_all_done", {31'h0, all_done}, 32'h1);
    chk("rst_readdata", citron_readdata, 32'h0);
    rst_n = 1'b1;
    idle(2);

    bus_rd(3'd1, 32'h0006_0800, "rst_stat");
    bus_rd(3'd2, 32'h0000_01B2, "rst_div");
    bus_rd(3'd3, 32'h0000_0003, "rst_ctrl");
    bus_rd(3'd4, 32'h0000_0000, "rst_flags");
    bus_rd(3'd5, 32'h0000_0000, "reg5_zero");
    bus_wr(3'd2, 32'h0000_0005);
    bus_rd(3'd2, 32'h0000_0010, "div_clamp");

    // 1: 0x55 at DIV=16, 160-clock frame, all_done afterwards
    e.b = 8'h55; e.div = 16; tx_exp_q.push_back(e);
    bus_wr(3'd0, 32'h5500_0000);
    k = 0;
    while (TX && k < 50) begin @(negedge clk); k++; end
    chk("t1_tx_fell", {31'h0, TX}, 32'h0);
    n = 0;
    while (!all_done && n < 400) begin @(negedge clk); n++; end
    chk("t1_frame_len", n, 160);

    // 2: one byte in flight, then TX_DEPTH+1 pushes -> full + overflow
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin e.b = 8'hA0 + 8'(i); e.div = 16; tx_exp_q.push_back(e); end
      bus_wr(3'd0, {8'hA0 + 8'(i), 24'h0});
    end
    bus_rd(3'd1, 32'h0003_0000, "t2_stat_full");
    bus_rd(3'd4, 32'h0000_0008, "t2_tx_ovf");
    bus_wr(3'd4, 32'h0000_0008);
    bus_rd(3'd4, 32'h0000_0000, "t2_ovf_cleared");
    wait_done(2000, "t2_drained");

    // 3: nine RX frames into an 8-deep FIFO
    bus_wr(3'd3, 32'h0000_0103);
    for (int i = 1; i <= 9; i++) send_rx(8'(i), 8, 1'b0, 1'b0, 1'b1, 16);
    chk("t3_irq_rx", {31'h0, irq}, 32'h1);
    bus_rd(3'd1, 32'h0004_0808, "t3_stat");
    bus_rd(3'd4, 32'h0000_0001, "t3_overrun");
    for (int i = 1; i <= 8; i++) bus_rd(3'd0, {8'(i), 24'h0}, "t3_rx_byte");
    bus_rd(3'd0, 32'hFFFF_0000, "t3_rx_empty");
    idle(3);
    chk("t3_irq_clear", {31'h0, irq}, 32'h0);
    bus_wr(3'd4, 32'h0000_0001);

    // 4: 7E1 with wrong parity (0x41 even parity is 0, send 1); bit 7 not received
    bus_wr(3'd3, 32'h0000_0406);
    bus_rd(3'd3, 32'h0000_0406, "t4_ctrl");
    send_rx(8'hC1, 7, 1'b1, 1'b1, 1'b1, 16);
    idle(3);
    chk("t4_irq_err", {31'h0, irq}, 32'h1);
    bus_rd(3'd4, 32'h0000_0002, "t4_parity_err");
    bus_rd(3'd0, 32'h4100_0000, "t4_rx_byte");
    bus_wr(3'd4, 32'h0000_0002);
    idle(3);
    chk("t4_irq_off", {31'h0, irq}, 32'h0);

    // 5: framing error, then a quarter-bit glitch, then a clean frame
    bus_wr(3'd3, 32'h0000_0403);
    send_rx(8'h5A, 8, 1'b0, 1'b0, 1'b0, 16);
    bus_rd(3'd4, 32'h0000_0004, "t5_framing_err");
    bus_rd(3'd0, 32'h5A00_0000, "t5_rx_byte");
    bus_wr(3'd4, 32'h0000_0004);
    @(negedge clk); RX = 1'b0;
    idle(4);
    RX = 1'b1;
    idle(48);
    bus_rd(3'd1, 32'h0006_0800, "t5_glitch_stat");
    send_rx(8'h96, 8, 1'b0, 1'b0, 1'b1, 16);
    bus_rd(3'd0, 32'h9600_0000, "t5_after_glitch");
    bus_rd(3'd4, 32'h0000_0000, "t5_flags_clean");

    // 6: divisor change mid-frame, then reset mid-frame
    bus_wr(3'd2, 32'h0000_01B2);
    e.b = 8'h0F; e.div = 434; tx_exp_q.push_back(e);
    bus_wr(3'd0, 32'h0F00_0000);
    idle(1000);
    bus_wr(3'd2, 32'h0000_006C);
    bus_rd(3'd2, 32'h0000_006C, "t6_div_new");
    e.b = 8'h3C; e.div = 108; tx_exp_q.push_back(e);
    bus_wr(3'd0, 32'h3C00_0000);
    wait_done(7000, "t6_done");

    bus_wr(3'd0, 32'h0000_0000);
    k = 0;
    while (TX && k < 50) begin @(negedge clk); k++; end
    chk("t6_tx_low_before_rst", {31'h0, TX}, 32'h0);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_tx_high", {31'h0, TX}, 32'h1);
    chk("t6_rst_all_done", {31'h0, all_done}, 32'h1);
    chk("t6_rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    bus_rd(3'd2, 32'h0000_01B2, "t6_rst_div");
    bus_rd(3'd1, 32'h0006_0800, "t6_rst_stat");

    idle(5);
    chk("tx_frames_seen", tx_exp_q.size(), 0);
    chk("rd_scoreboard_drained", rd_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
